nn_solver_sequencer: RTL and testbench
======================================

# nn_solver_sequencer

Control sequencer for the neural-network nonlinear-equation solver datapath. It sits directly upstream of the forward/backward engine, training block and weight buffers. It drives their read, write, enable and phase strobes so that one training iteration runs as a fixed cycle schedule: load the initial guess, propagate, write back updated weights, then wait out the update penalty. It counts iterations, honours early termination from the training block, and finally streams the best weights out of the best-weight buffer.

## Interface
- NUM_UNKNOWNS, 2: weights streamed per load/update phase (one per cycle).
- PIPE_LATENCY, 4: cycles from the last weight entering the forward engine to error/delta valid at the training block.
- EXTRA_CYCLES, 3: cycles wasted after each weight update.
- MAX_ITERS, 16: iteration limit; must be at least 2.
- ITER_WIDTH, 8: width of the iteration counter; must satisfy 2^ITER_WIDTH > MAX_ITERS.

Ports:
- CLK  in  1  the only clock; all state changes on its rising edge.
- RESET  in  1  synchronous, active-high.
- START  in  1  level; sampled only in IDLE.
- TRAINING_MODE  in  1  1 = Manhattan, 0 = Adam; latched when START is accepted.
- TRAINING_DONE  in  1  target error reached; from the training block.
- INITIAL_READ_FLAG  out  1  selects the initial-guess ROM as the datapath input and writes the old-weight buffer.
- OLD_WEIGHT_RD  out  1  pops the old-weight buffer.
- WRITE_TRAINING  out  1  writes the updated weight to the old-weight buffer.
- STALL  out  1  training-block hold strobe.
- FINISH  out  1  pops the best-weight buffer and switches the mux to best weights.
- FINISH_FIRST_MANHATTAN_ITER  out  1  one-cycle pulse.
- FINISH_SECOND_MANHATTAN_ITER  out  1  one-cycle pulse.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle completion pulse.
- ITER_COUNT  out  ITER_WIDTH  number of completed iterations.

## Operation
The sequencer is a Moore FSM with these states:
- IDLE: all outputs 0. START=1 → INIT_LOAD, clears ITER_COUNT, latches TRAINING_MODE.
- INIT_LOAD: runs NUM_UNKNOWNS cycles with INITIAL_READ_FLAG=1 → PROPAGATE.
- PROPAGATE: runs PIPE_LATENCY cycles with all strobes 0 → UPDATE.
- UPDATE: runs NUM_UNKNOWNS cycles with OLD_WEIGHT_RD=1 and WRITE_TRAINING=1. On its last cycle ITER_COUNT increments. Exit:
  - → FINISH if the new count equals MAX_ITERS or the done latch is set.
  - → WASTE otherwise.
- WASTE: runs EXTRA_CYCLES cycles with STALL=1 → PROPAGATE.
- FINISH: runs NUM_UNKNOWNS cycles with FINISH=1 → DONE_ST.
- DONE_ST: one cycle with DONE=1 → IDLE.

Counters and flags:
- One phase counter is shared by all timed states. It reloads on every state entry and is sized for the largest of NUM_UNKNOWNS, PIPE_LATENCY and EXTRA_CYCLES.
- Manhattan pulses apply only when the latched mode is 1. FINISH_FIRST_MANHATTAN_ITER pulses on the last UPDATE cycle of iteration 0. FINISH_SECOND_MANHATTAN_ITER pulses on the last UPDATE cycle of iteration 1. In Adam mode neither ever asserts.
- The done latch sets when TRAINING_DONE=1 in INIT_LOAD, PROPAGATE, UPDATE or WASTE. It clears in IDLE.
  - In PROPAGATE or WASTE the latch forces → FINISH on the next edge.
  - In INIT_LOAD or UPDATE the current phase completes first, so no partial buffer write occurs. INIT_LOAD then goes to FINISH, not PROPAGATE.
- START while BUSY is ignored. TRAINING_MODE changes while BUSY are ignored.
- ITER_COUNT saturates at MAX_ITERS and holds its value through DONE_ST and IDLE until the next accepted START.

## Timing
- All outputs decode from registered state/counters only; there is no combinational path from input to output.
- Reset value of every output is 0, including ITER_COUNT. The state resets to IDLE.
- RESET mid-operation forces IDLE on that edge, with all outputs 0 in the next cycle. Buffer contents are not this block's concern.
- START is high at edge k in IDLE → INIT_LOAD is occupied for cycles k+1 … k+NUM_UNKNOWNS.
- Iteration period is PIPE_LATENCY + NUM_UNKNOWNS + EXTRA_CYCLES cycles; the last iteration has no WASTE.
- TRAINING_DONE seen in PROPAGATE at cycle c → FINISH=1 at c+1.
- At most one of INITIAL_READ_FLAG, WRITE_TRAINING, STALL, FINISH is high in any cycle.

## Structure
- A shared solver package holds the state enum and the PHASE_CNT_W constant (clog2 of the maximum phase length). The training block reuses the mode encoding: MODE_MANHATTAN=1, MODE_ADAM=0.
- One sub-module is natural: phase_timer, a loadable down-counter with a last-cycle flag.

## Test plan
All scenarios use NUM_UNKNOWNS=2, PIPE_LATENCY=4, EXTRA_CYCLES=3, MAX_ITERS=3, with START at cycle 0.
- Full run, Adam mode:
  - INITIAL_READ_FLAG high cycles 1–2.
  - UPDATE at 7–8, 16–17 and 25–26.
  - STALL at 9–11 and 18–20.
  - FINISH at 27–28, DONE at 29, ITER_COUNT=3.
  - No Manhattan pulses.
- Manhattan mode: FINISH_FIRST_MANHATTAN_ITER pulses only at cycle 8, FINISH_SECOND_MANHATTAN_ITER only at cycle 17.
- Early termination:
  - TRAINING_DONE at cycle 13 (PROPAGATE) → FINISH 14–15, DONE 16, ITER_COUNT=1.
  - TRAINING_DONE at cycle 7 (UPDATE) → UPDATE completes at 8, then FINISH 9–10.
- RESET at cycle 10, then START again at cycle 12 → all outputs 0 at 11, and INIT_LOAD at 13–14 with ITER_COUNT=0.
- Toggling START and TRAINING_MODE while BUSY → no schedule change. An assertion checks output mutual exclusion on every cycle.

Source files
------------

// File: rtl/nn_solver_sequencer_pkg.sv
// Shared definitions for the NN solver control path: sequencer states,
// training-mode encoding and phase-counter sizing.
package nn_solver_sequencer_pkg;

   typedef logic [2:0] seq_state_t;

   localparam seq_state_t ST_IDLE      = 3'd0;
   localparam seq_state_t ST_INIT_LOAD = 3'd1;
   localparam seq_state_t ST_PROPAGATE = 3'd2;
   localparam seq_state_t ST_UPDATE    = 3'd3;
   localparam seq_state_t ST_WASTE     = 3'd4;
   localparam seq_state_t ST_FINISH    = 3'd5;
   localparam seq_state_t ST_DONE      = 3'd6;

   // Mode encoding shared with the training block.
   localparam logic MODE_MANHATTAN = 1'b1;
   localparam logic MODE_ADAM      = 1'b0;

   // Width of a down-counter that must hold (longest phase - 1).
   function automatic int unsigned phase_cnt_w(input int unsigned a,
                                               input int unsigned b,
                                               input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m > 1) ? 32'($clog2(m)) : 32'd1;
   endfunction

   localparam int unsigned PHASE_CNT_W = phase_cnt_w(2, 4, 3);

endpackage

// File: rtl/nn_solver_sequencer_phase_timer.sv
// Loadable down-counter timing the current sequencer phase; flags the
// last cycle of the phase now and the last cycle as seen after the next edge.
module nn_solver_sequencer_phase_timer
   import nn_solver_sequencer_pkg::*;
#(
   parameter int unsigned W = PHASE_CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         last_c,
   output logic         last_nxt_c
);

   logic [W-1:0] cnt;

   // Reload on phase entry, otherwise count down and park at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign last_c     = (cnt == '0);
   assign last_nxt_c = load ? (load_val == '0) : (cnt <= W'(1));

endmodule

// File: rtl/nn_solver_sequencer.sv
// Cycle-schedule sequencer for the NN nonlinear solver: initial load,
// propagate / update / waste iterations, early exit, best-weight readout.
module nn_solver_sequencer
   import nn_solver_sequencer_pkg::*;
#(
   parameter int unsigned NUM_UNKNOWNS = 2,
   parameter int unsigned PIPE_LATENCY = 4,
   parameter int unsigned EXTRA_CYCLES = 3,
   parameter int unsigned MAX_ITERS    = 16,
   parameter int unsigned ITER_WIDTH   = 8
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  START,
   input  logic                  TRAINING_MODE,
   input  logic                  TRAINING_DONE,
   output logic                  INITIAL_READ_FLAG,
   output logic                  OLD_WEIGHT_RD,
   output logic                  WRITE_TRAINING,
   output logic                  STALL,
   output logic                  FINISH,
   output logic                  FINISH_FIRST_MANHATTAN_ITER,
   output logic                  FINISH_SECOND_MANHATTAN_ITER,
   output logic                  BUSY,
   output logic                  DONE,
   output logic [ITER_WIDTH-1:0] ITER_COUNT
);

   localparam int unsigned PH_W = phase_cnt_w(NUM_UNKNOWNS, PIPE_LATENCY, EXTRA_CYCLES);
   localparam logic [PH_W-1:0] LD_NU = PH_W'(NUM_UNKNOWNS - 1);
   localparam logic [PH_W-1:0] LD_PL = PH_W'(PIPE_LATENCY - 1);
   localparam logic [PH_W-1:0] LD_EC = PH_W'(EXTRA_CYCLES - 1);
   localparam logic [ITER_WIDTH-1:0] ITER_MAX = ITER_WIDTH'(MAX_ITERS);

   seq_state_t            state_q, state_nxt;
   logic [ITER_WIDTH-1:0] iter_q, iter_nxt, iter_inc;
   logic                  mode_q, mode_nxt;
   logic                  latch_q, latch_nxt;
   logic                  done_eff;
   logic                  phase_load;
   logic [PH_W-1:0]       phase_val;
   logic                  phase_last;
   logic                  phase_last_nxt;

   logic irf_nxt, upd_nxt, stall_nxt, fin_nxt, m1_nxt, m2_nxt, busy_nxt, done_nxt;

   nn_solver_sequencer_phase_timer #(
      .W (PH_W)
   ) u_phase_timer (
      .clk        (CLK),
      .rst        (RESET),
      .load       (phase_load),
      .load_val   (phase_val),
      .last_c     (phase_last),
      .last_nxt_c (phase_last_nxt)
   );

   // State, iteration count, mode/done latches and registered strobes.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q                      <= ST_IDLE;
         iter_q                       <= '0;
         mode_q                       <= MODE_ADAM;
         latch_q                      <= 1'b0;
         INITIAL_READ_FLAG            <= 1'b0;
         OLD_WEIGHT_RD                <= 1'b0;
         WRITE_TRAINING               <= 1'b0;
         STALL                        <= 1'b0;
         FINISH                       <= 1'b0;
         FINISH_FIRST_MANHATTAN_ITER  <= 1'b0;
         FINISH_SECOND_MANHATTAN_ITER <= 1'b0;
         BUSY                         <= 1'b0;
         DONE                         <= 1'b0;
      end else begin
         state_q                      <= state_nxt;
         iter_q                       <= iter_nxt;
         mode_q                       <= mode_nxt;
         latch_q                      <= latch_nxt;
         INITIAL_READ_FLAG            <= irf_nxt;
         OLD_WEIGHT_RD                <= upd_nxt;
         WRITE_TRAINING               <= upd_nxt;
         STALL                        <= stall_nxt;
         FINISH                       <= fin_nxt;
         FINISH_FIRST_MANHATTAN_ITER  <= m1_nxt;
         FINISH_SECOND_MANHATTAN_ITER <= m2_nxt;
         BUSY                         <= busy_nxt;
         DONE                         <= done_nxt;
      end
   end

   assign ITER_COUNT = iter_q;
   assign iter_inc   = (iter_q >= ITER_MAX) ? iter_q : iter_q + ITER_WIDTH'(1);

   // Next-state, counter and latch update; phase timer reloads on any state change.
   always_comb begin
      state_nxt = state_q;
      iter_nxt  = iter_q;
      mode_nxt  = mode_q;
      latch_nxt = latch_q;
      done_eff  = latch_q | TRAINING_DONE;
      phase_val = '0;

      case (state_q)
         ST_IDLE: begin
            latch_nxt = 1'b0;
            if (START) begin
               state_nxt = ST_INIT_LOAD;
               iter_nxt  = '0;
               mode_nxt  = TRAINING_MODE;
            end
         end
         ST_INIT_LOAD: begin
            latch_nxt = done_eff;
            if (phase_last) begin
               state_nxt = done_eff ? ST_FINISH : ST_PROPAGATE;
            end
         end
         ST_PROPAGATE: begin
            latch_nxt = done_eff;
            if (done_eff) begin
               state_nxt = ST_FINISH;
            end else if (phase_last) begin
               state_nxt = ST_UPDATE;
            end
         end
         ST_UPDATE: begin
            latch_nxt = done_eff;
            if (phase_last) begin
               iter_nxt  = iter_inc;
               state_nxt = ((iter_inc == ITER_MAX) || done_eff) ? ST_FINISH : ST_WASTE;
            end
         end
         ST_WASTE: begin
            latch_nxt = done_eff;
            if (done_eff) begin
               state_nxt = ST_FINISH;
            end else if (phase_last) begin
               state_nxt = ST_PROPAGATE;
            end
         end
         ST_FINISH: begin
            if (phase_last) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      phase_load = (state_nxt != state_q);
      case (state_nxt)
         ST_INIT_LOAD, ST_UPDATE, ST_FINISH: phase_val = LD_NU;
         ST_PROPAGATE:                       phase_val = LD_PL;
         ST_WASTE:                           phase_val = LD_EC;
         default:                            phase_val = '0;
      endcase
   end

   // Strobe decode of the upcoming state, registered on the next edge.
   always_comb begin
      irf_nxt   = (state_nxt == ST_INIT_LOAD);
      upd_nxt   = (state_nxt == ST_UPDATE);
      stall_nxt = (state_nxt == ST_WASTE);
      fin_nxt   = (state_nxt == ST_FINISH);
      busy_nxt  = (state_nxt != ST_IDLE);
      done_nxt  = (state_nxt == ST_DONE);
      m1_nxt    = 1'b0;
      m2_nxt    = 1'b0;
      if ((mode_nxt == MODE_MANHATTAN) && upd_nxt && phase_last_nxt) begin
         m1_nxt = (iter_nxt == ITER_WIDTH'(0));
         m2_nxt = (iter_nxt == ITER_WIDTH'(1));
      end
   end

endmodule

// File: tb/tb_nn_solver_sequencer.sv
// Self-checking bench for nn_solver_sequencer: directed schedules plus
// randomized runs against a phase-level schedule model.
module tb_nn_solver_sequencer;

   localparam int NU   = 2;
   localparam int PL   = 4;
   localparam int EC   = 3;
   localparam int MAXI = 3;
   localparam int IW   = 8;

   localparam int K_IDLE  = 0;
   localparam int K_INIT  = 1;
   localparam int K_PROP  = 2;
   localparam int K_UPD   = 3;
   localparam int K_WASTE = 4;
   localparam int K_FIN   = 5;
   localparam int K_DONE  = 6;

   logic          CLK = 1'b0;
   logic          RESET = 1'b1;
   logic          START = 1'b0;
   logic          TRAINING_MODE = 1'b0;
   logic          TRAINING_DONE = 1'b0;
   logic          INITIAL_READ_FLAG, OLD_WEIGHT_RD, WRITE_TRAINING, STALL, FINISH;
   logic          FINISH_FIRST_MANHATTAN_ITER, FINISH_SECOND_MANHATTAN_ITER, BUSY, DONE;
   logic [IW-1:0] ITER_COUNT;
   logic [16:0]   obs;

   int n_tests = 0;
   int n_fail  = 0;

   logic [16:0] exp_vec [0:63];
   int          exp_len;
   int          exp_done;

   nn_solver_sequencer #(
      .NUM_UNKNOWNS (NU),
      .PIPE_LATENCY (PL),
      .EXTRA_CYCLES (EC),
      .MAX_ITERS    (MAXI),
      .ITER_WIDTH   (IW)
   ) dut (
      .CLK                          (CLK),
      .RESET                        (RESET),
      .START                        (START),
      .TRAINING_MODE                (TRAINING_MODE),
      .TRAINING_DONE                (TRAINING_DONE),
      .INITIAL_READ_FLAG            (INITIAL_READ_FLAG),
      .OLD_WEIGHT_RD                (OLD_WEIGHT_RD),
      .WRITE_TRAINING               (WRITE_TRAINING),
      .STALL                        (STALL),
      .FINISH                       (FINISH),
      .FINISH_FIRST_MANHATTAN_ITER  (FINISH_FIRST_MANHATTAN_ITER),
      .FINISH_SECOND_MANHATTAN_ITER (FINISH_SECOND_MANHATTAN_ITER),
      .BUSY                         (BUSY),
      .DONE                         (DONE),
      .ITER_COUNT                   (ITER_COUNT)
   );

   always #5 CLK = ~CLK;

   assign obs = {INITIAL_READ_FLAG, OLD_WEIGHT_RD, WRITE_TRAINING, STALL, FINISH,
                 FINISH_FIRST_MANHATTAN_ITER, FINISH_SECOND_MANHATTAN_ITER,
                 BUSY, DONE, ITER_COUNT};

   // Datapath strobes must never overlap.
   always @(negedge CLK) begin
      n_tests++;
      assert ($countones({INITIAL_READ_FLAG, WRITE_TRAINING, STALL, FINISH}) <= 1)
      else begin
         n_fail++;
         $error("FAIL mutex at %0t: observed irf/wt/stall/fin=%b required at most one high",
                $time, {INITIAL_READ_FLAG, WRITE_TRAINING, STALL, FINISH});
      end
   end

   function automatic logic [16:0] mk(input int kind, input int it, input bit m1, input bit m2);
      logic [16:0] v;
      v       = '0;
      v[16]   = (kind == K_INIT);
      v[15]   = (kind == K_UPD);
      v[14]   = (kind == K_UPD);
      v[13]   = (kind == K_WASTE);
      v[12]   = (kind == K_FIN);
      v[11]   = m1;
      v[10]   = m2;
      v[9]    = (kind != K_IDLE);
      v[8]    = (kind == K_DONE);
      v[7:0]  = 8'(it);
      return v;
   endfunction

   // Phase-level schedule model: cycle 1 is the first cycle after START is taken.
   task automatic build_model(input logic mode, input int td);
      int t, it;
      bit stop;
      t = 1; it = 0; stop = 0;
      for (int i = 0; i < 64; i++) exp_vec[i] = '0;
      for (int k = 0; k < NU; k++) begin
         exp_vec[t] = mk(K_INIT, it, 0, 0);
         if (t == td) stop = 1;
         t++;
      end
      while (!stop) begin
         for (int k = 0; k < PL && !stop; k++) begin
            exp_vec[t] = mk(K_PROP, it, 0, 0);
            if (t == td) stop = 1;
            t++;
         end
         if (stop) break;
         for (int k = 0; k < NU; k++) begin
            exp_vec[t] = mk(K_UPD, it, mode && (k == NU-1) && (it == 0),
                                       mode && (k == NU-1) && (it == 1));
            if (t == td) stop = 1;
            t++;
         end
         it++;
         if (it == MAXI || stop) break;
         for (int k = 0; k < EC && !stop; k++) begin
            exp_vec[t] = mk(K_WASTE, it, 0, 0);
            if (t == td) stop = 1;
            t++;
         end
      end
      for (int k = 0; k < NU; k++) begin
         exp_vec[t] = mk(K_FIN, it, 0, 0);
         t++;
      end
      exp_vec[t] = mk(K_DONE, it, 0, 0);
      exp_done = t;
      t++;
      exp_vec[t] = mk(K_IDLE, it, 0, 0);
      t++;
      exp_vec[t] = mk(K_IDLE, it, 0, 0);
      exp_len = t;
   endtask

   task automatic check(input string tag, input int t, input logic [16:0] expv);
      n_tests++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s cycle %0d: observed %h expected %h", tag, t, obs, expv);
      end
   endtask

   // One START-to-idle run; optional input noise while busy and mid-run reset.
   task automatic run(input string tag, input logic mode, input int td,
                      input bit noise, input int rst_at);
      build_model(mode, td);
      START = 1'b1;
      TRAINING_MODE = mode;
      @(posedge CLK); #1;
      START = 1'b0;
      for (int t = 1; t <= exp_len; t++) begin
         TRAINING_DONE = (t == td);
         RESET = (t == rst_at);
         if (noise && t < exp_done) begin
            START = 1'($urandom_range(0, 1));
            TRAINING_MODE = 1'($urandom_range(0, 1));
         end else begin
            START = 1'b0;
         end
         @(negedge CLK);
         check(tag, t, exp_vec[t]);
         @(posedge CLK); #1;
         if (t == rst_at) begin
            RESET = 1'b0;
            TRAINING_DONE = 1'b0;
            START = 1'b0;
            @(negedge CLK);
            check({tag, "_after_reset"}, t + 1, 17'h0);
            @(posedge CLK); #1;
            break;
         end
      end
      TRAINING_DONE = 1'b0;
      START = 1'b0;
      RESET = 1'b0;
   endtask

   initial begin
      logic rmode;
      int   rtd;
      RESET = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      RESET = 1'b0;
      @(negedge CLK);
      check("reset_state", 0, 17'h0);
      @(posedge CLK); #1;

      run("adam_full", 1'b0, 0, 1'b0, 0);
      run("manhattan_full", 1'b1, 0, 1'b0, 0);
      run("early_propagate", 1'b0, 13, 1'b0, 0);
      run("early_update", 1'b1, 7, 1'b0, 0);
      run("early_init", 1'b1, 2, 1'b0, 0);
      run("early_waste", 1'b0, 19, 1'b0, 0);
      run("reset_mid", 1'b0, 0, 1'b0, 10);
      run("restart", 1'b1, 0, 1'b0, 0);
      run("busy_noise", 1'b1, 0, 1'b1, 0);
      for (int i = 0; i < 8; i++) begin
         rmode = 1'($urandom_range(0, 1));
         rtd   = int'($urandom_range(0, 34));
         run("random", rmode, rtd, 1'b1, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
